// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by alu and alu_arbiter.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ADD/SUB with carry, signed overflow, zero and negative flags.
// Illegal opcodes return a zero result with carry and overflow cleared.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    logic             is_add;
    logic             is_sub;
    logic             legal;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // SUB is a + ~b + 1, so carry-out doubles as the no-borrow flag
    always_comb begin
        is_add   = op == OP_ADD;
        is_sub   = op == OP_SUB;
        legal    = is_add | is_sub;
        b_eff    = is_sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        y        = legal ? sum[WIDTH-1:0] : '0;
        carry    = legal & sum[WIDTH];
        overflow = legal & (a[WIDTH-1] == b_eff[WIDTH-1]) & (y[WIDTH-1] != a[WIDTH-1]);
        zero     = y == '0;
        negative = y[WIDTH-1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu between two valid/ready requesters.
// Optional rsp_err flag for illegal opcodes when ALU_ARB_ILLEGAL_OP_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic             rsp_err,
`endif
    output logic             rsp_negative
);
    state_t           state_q, state_d;
    logic             last_id_q, last_id_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_c_q, rsp_c_d, rsp_v_q, rsp_v_d;
    logic             rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c, alu_v, alu_z, alu_n;
    logic             gnt, accept, exec, done;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .y        (alu_y),
        .carry    (alu_c),
        .overflow (alu_v),
        .zero     (alu_z),
        .negative (alu_n)
    );

    // A tie goes to whichever requester was not served last
    always_comb begin
        gnt    = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;
        accept = (state_q == IDLE) & (req0_valid | req1_valid);
        exec   = state_q == EXEC;
        done   = (state_q == RESP) & rsp_valid_q & rsp_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP :
                  done ? IDLE : RESP;
    end

    always_comb begin
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        rsp_valid    = rsp_valid_q;
        rsp_id       = rsp_id_q;
        rsp_y        = rsp_y_q;
        rsp_carry    = rsp_c_q;
        rsp_overflow = rsp_v_q;
        rsp_zero     = rsp_z_q;
        rsp_negative = rsp_n_q;
    end

    always_comb begin
        a_d         = accept ? (gnt ? req1_a : req0_a) : a_q;
        b_d         = accept ? (gnt ? req1_b : req0_b) : b_q;
        op_d        = accept ? (gnt ? req1_op : req0_op) : op_q;
        id_d        = accept ? gnt : id_q;
        last_id_d   = accept ? gnt : last_id_q;
        rsp_valid_d = exec | (rsp_valid_q & ~done);
        rsp_id_d    = exec ? id_q : rsp_id_q;
        rsp_y_d     = exec ? alu_y : rsp_y_q;
        rsp_c_d     = exec ? alu_c : rsp_c_q;
        rsp_v_d     = exec ? alu_v : rsp_v_q;
        rsp_z_d     = exec ? alu_z : rsp_z_q;
        rsp_n_d     = exec ? alu_n : rsp_n_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            last_id_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_id_q   <= last_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_c_q     <= rsp_c_d;
            rsp_v_q     <= rsp_v_d;
            rsp_z_q     <= rsp_z_d;
            rsp_n_q     <= rsp_n_d;
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic rsp_err_q, rsp_err_d;

    always_comb begin
        rsp_err_d = exec ? (op_q > OP_SUB) : rsp_err_q;
        rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rsp_err_q <= 1'b0;
        else     rsp_err_q <= rsp_err_d;
    end
`endif
endmodule
